// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
// Contents:
//   uart_state_e             - frame state machine encoding (idle/start/data/stop/break)
//   ClkPerHalfBitDefault     - default clk cycles per half bit period
//   DataBits                 - data bits per frame (8N1)
//   StopSampleHalfBits       - stop bit sample offset from t0, in half bit periods
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } uart_state_e;

  localparam int unsigned ClkPerHalfBitDefault = 434;
  localparam int unsigned DataBits             = 8;
  localparam int unsigned StopSampleHalfBits   = 19;

endpackage

// File: rtl/uart_rx_if.sv
// Byte-side handshake between the UART receiver and its consumer.
// Signals:
//   rdata    - received byte, stable while rx_valid=1
//   rx_valid - byte available, held until acked
//   rx_ack   - consumer accepts rdata
//   ferr     - one-cycle pulse: stop bit sampled low
//   overrun  - one-cycle pulse: completed byte dropped, previous one not yet taken
// Modports: master = receiver side, slave = consumer side.
interface uart_rx_if;
  logic [7:0] rdata;
  logic       rx_valid;
  logic       rx_ack;
  logic       ferr;
  logic       overrun;

  modport master (
    output rdata,
    output rx_valid,
    output ferr,
    output overrun,
    input  rx_ack
  );

  modport slave (
    input  rdata,
    input  rx_valid,
    input  ferr,
    input  overrun,
    output rx_ack
  );
endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk  - system clock
//   rstn - synchronous active-low reset; both flops load ResetVal
//   d    - asynchronous input
//   q    - synchronized output (two cycles of latency)
module uart_sync #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 asynchronous serial receiver, LSB first, with valid/ack byte handshake.
// Detects false start bits, framing errors (stop bit low) and overrun.
// Ports:
//   clk     - system clock
//   rstn    - synchronous active-low reset
//   rxd     - asynchronous serial input, idle high
//   rx_busy - high whenever a frame is being received or a break is pending
//   bus     - byte handshake (rdata, rx_valid, rx_ack, ferr, overrun)
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_HALF_BIT = ClkPerHalfBitDefault
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          rxd,
  output logic          rx_busy,
  uart_rx_if.master     bus
);

  localparam logic [31:0] HalfM1  = 32'(CLK_PER_HALF_BIT - 1);
  localparam logic [31:0] FullM1  = 32'(2 * CLK_PER_HALF_BIT - 1);
  localparam logic [2:0]  LastBit = 3'(DataBits - 1);

  logic        rxd_s;
  uart_state_e state_q;
  logic [31:0] cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic [7:0]  rdata_q;
  logic        valid_q;
  logic        ferr_q;
  logic        overrun_q;

  uart_sync #(
    .ResetVal (1'b1)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (rxd),
    .q    (rxd_s)
  );

  // The counter restarts at every sample point, so each sample lands exactly
  // 2H cycles after the previous one and the start sample H cycles after t0.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      rdata_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
      cnt_q     <= cnt_q + 32'd1;

      // A completion in the same cycle overrides this clear below.
      if (valid_q && bus.rx_ack) begin
        valid_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (!rxd_s) begin
            cnt_q   <= '0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (cnt_q == HalfM1) begin
            cnt_q <= '0;
            if (rxd_s) begin
              state_q <= StIdle;  // false start
            end else begin
              bit_idx_q <= '0;
              state_q   <= StData;
            end
          end
        end
        StData: begin
          if (cnt_q == FullM1) begin
            cnt_q   <= '0;
            shift_q <= {rxd_s, shift_q[7:1]};
            if (bit_idx_q == LastBit) begin
              state_q <= StStop;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        StStop: begin
          if (cnt_q == FullM1) begin
            if (rxd_s) begin
              // Leave at mid stop bit so a shortened stop bit is tolerated.
              state_q <= StIdle;
              if (!valid_q || bus.rx_ack) begin
                rdata_q <= shift_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              ferr_q  <= 1'b1;
              state_q <= StBreak;
            end
          end
        end
        StBreak: begin
          // Hold off until the line is released so a stuck-low rxd
          // does not look like a stream of start bits.
          if (rxd_s) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rx_busy      = (state_q != StIdle);
  assign bus.rdata    = rdata_q;
  assign bus.rx_valid = valid_q;
  assign bus.ferr     = ferr_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with H=4 (8 clk cycles per bit).
// Stimulus pushes expected events (byte / ferr / overrun) into a queue; a
// monitor pops and compares whenever the DUT presents one of them.
module tb_uart_rx;

  localparam int unsigned H  = 4;
  localparam int          Bp = 2 * H;

  localparam int EvByte = 0;
  localparam int EvFerr = 1;
  localparam int EvOvr  = 2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic rstn;
  logic rxd;
  logic rx_busy;
  logic force_ack;
  logic auto_ack;
  logic ack_auto_q;

  uart_rx_if bus ();

  uart_rx #(
    .CLK_PER_HALF_BIT (H)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .rxd     (rxd),
    .rx_busy (rx_busy),
    .bus     (bus)
  );

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs only ever change on the falling edge.
  always @(negedge clk) ack_auto_q <= auto_ack && bus.rx_valid;
  assign bus.rx_ack = force_ack | ack_auto_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input int kind, input logic [7:0] data);
    exp_t e;
    e.kind = 2'(kind);
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic check_event(input int kind, input logic [7:0] data);
    exp_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_event: got kind %0d data %02h, required no event", kind, data);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      if (kind == EvByte) check("event_rdata", 32'(data), 32'(e.data));
    end
  endtask

  // Monitor: a new byte is presented when rx_valid is high after an edge at
  // which either it was low or the previous byte was being acked.
  initial begin
    logic valid_prev;
    valid_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rstn) begin
        valid_prev = 1'b0;
      end else begin
        if (bus.rx_valid && (!valid_prev || bus.rx_ack)) check_event(EvByte, bus.rdata);
        if (bus.ferr) check_event(EvFerr, 8'h00);
        if (bus.overrun) check_event(EvOvr, 8'h00);
        valid_prev = bus.rx_valid;
      end
    end
  end

  task automatic drive_bit(input logic v, input int n);
    @(negedge clk);
    rxd = v;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int stop_cycles, input logic stop_val);
    drive_bit(1'b0, Bp);
    for (int i = 0; i < 8; i++) drive_bit(d[i], Bp);
    drive_bit(stop_val, stop_cycles);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdata"}, 32'(bus.rdata), 32'h0);
    check({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'h0);
    check({tag, "_ferr"}, 32'(bus.ferr), 32'h0);
    check({tag, "_overrun"}, 32'(bus.overrun), 32'h0);
    check({tag, "_rx_busy"}, 32'(rx_busy), 32'h0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rstn        = 1'b0;
    rxd         = 1'b1;
    force_ack   = 1'b0;
    auto_ack    = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // 1: single frame, latency to rx_valid, ack clears next cycle
    push_exp(EvByte, 8'hA5);
    fork
      send_frame(8'hA5, Bp, 1'b1);
      begin
        repeat (79) @(negedge clk);
        check("s1_valid_before_t0p77", 32'(bus.rx_valid), 32'h0);
        @(negedge clk);
        check("s1_valid_at_t0p77", 32'(bus.rx_valid), 32'h1);
        check("s1_rdata", 32'(bus.rdata), 32'hA5);
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        check("s1_valid_after_ack", 32'(bus.rx_valid), 32'h0);
      end
    join
    repeat (10) @(negedge clk);

    // 2: back-to-back frames with 0.9-bit stop bits, acked promptly
    auto_ack = 1'b1;
    push_exp(EvByte, 8'h00);
    push_exp(EvByte, 8'hFF);
    push_exp(EvByte, 8'h5A);
    send_frame(8'h00, Bp - 1, 1'b1);
    send_frame(8'hFF, Bp - 1, 1'b1);
    send_frame(8'h5A, Bp - 1, 1'b1);
    repeat (20) @(negedge clk);

    // 3: false start, busy drops at t0+5
    fork
      begin
        @(negedge clk);
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
      end
      begin
        repeat (7) @(negedge clk);
        check("s3_busy_at_t0p4", 32'(rx_busy), 32'h1);
        @(negedge clk);
        check("s3_busy_at_t0p5", 32'(rx_busy), 32'h0);
      end
    join
    repeat (20) @(negedge clk);

    // 4: framing error with line held low, then recovery
    push_exp(EvFerr, 8'h00);
    send_frame(8'h3C, 5 * Bp, 1'b0);
    drive_bit(1'b1, 2 * Bp);
    push_exp(EvByte, 8'h81);
    send_frame(8'h81, Bp, 1'b1);
    repeat (20) @(negedge clk);

    // 5: overrun without ack, then ack coinciding with completion
    auto_ack = 1'b0;
    push_exp(EvByte, 8'h11);
    send_frame(8'h11, Bp, 1'b1);
    push_exp(EvOvr, 8'h00);
    send_frame(8'h22, Bp, 1'b1);
    repeat (5) @(negedge clk);
    check("s5_rdata_kept", 32'(bus.rdata), 32'h11);
    check("s5_valid_kept", 32'(bus.rx_valid), 32'h1);
    push_exp(EvByte, 8'h22);
    fork
      send_frame(8'h22, Bp, 1'b1);
      begin
        repeat (79) @(negedge clk);
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    check("s5_rdata_replaced", 32'(bus.rdata), 32'h22);
    check("s5_valid_held", 32'(bus.rx_valid), 32'h1);

    // 6: reset during bit 3 of 0x77 (0x22 still pending), then a clean frame
    drive_bit(1'b0, Bp);
    drive_bit(1'b1, Bp);
    drive_bit(1'b1, Bp);
    drive_bit(1'b1, Bp);
    drive_bit(1'b0, H);
    check("s6_busy_mid_frame", 32'(rx_busy), 32'h1);
    @(negedge clk);
    rstn = 1'b0;
    rxd  = 1'b1;
    @(negedge clk);
    check_reset_outputs("s6_reset");
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    auto_ack = 1'b1;
    push_exp(EvByte, 8'h42);
    send_frame(8'h42, Bp, 1'b1);
    repeat (20) @(negedge clk);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
